wb_shared_bus: RTL and testbench

WB_SHARED_BUS -- requirements
Module: wb_shared_bus

---
 rtl/wb_shared_bus.sv | 205 ++++++++++++++++++++
 tb/tb_wb_shared_bus.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_shared_bus.sv
// Shared Wishbone bus: NM masters arbitrated round-robin onto NS slaves that are decoded from
// the top address bits. A watchdog ends transfers that stall for too long.
module wb_shared_bus #(
    parameter int NM        = 2,
    parameter int NS        = 4,
    parameter int AW        = 32,
    parameter int DW        = 32,
    parameter int SEL_BITS  = 4,
    parameter int TO_CYCLES = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NM-1:0]        m_cyc_i,
    input  logic [NM-1:0]        m_stb_i,
    input  logic [NM-1:0]        m_we_i,
    input  logic [NM*AW-1:0]     m_adr_i,
    input  logic [NM*DW-1:0]     m_dat_i,
    input  logic [NM*DW/8-1:0]   m_sel_i,
    output logic [DW-1:0]        m_dat_o,
    output logic [NM-1:0]        m_ack_o,
    output logic [NM-1:0]        m_err_o,
    output logic [NM-1:0]        m_rty_o,
    output logic [NS-1:0]        s_cyc_o,
    output logic [NS-1:0]        s_stb_o,
    output logic [AW-1:0]        s_adr_o,
    output logic [DW-1:0]        s_dat_o,
    output logic [DW/8-1:0]      s_sel_o,
    output logic                 s_we_o,
    input  logic [NS*DW-1:0]     s_dat_i,
    input  logic [NS-1:0]        s_ack_i,
    input  logic [NS-1:0]        s_err_i,
    input  logic [NS-1:0]        s_rty_i,
    output logic [NM-1:0]        gnt_o,
    output logic                 to_o,
    output logic                 dbg_busy
);

    localparam int OW = (NM > 1) ? $clog2(NM) : 1;
    localparam int SW = DW / 8;
    localparam logic [15:0] TO_LIMIT = 16'(TO_CYCLES);

    typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // Handshake: a master requests with cyc&stb; the transfer ends in the cycle where the
    // owner sees ack, err or rty. The owner holds the bus until it drops cyc.

    state_t          state_q, state_d;
    logic [OW-1:0]   owner_q, owner_d;
    logic [OW-1:0]   last_q, last_d;
    logic [NM-1:0]   gnt_d;
    logic [15:0]     wd_q, wd_d;

    logic            busy;
    logic            own_cyc, own_stb, own_we, own_req;
    logic [AW-1:0]   own_adr;
    logic [DW-1:0]   own_dat;
    logic [SW-1:0]   own_sel;
    logic [SEL_BITS-1:0] dec;
    logic [NS-1:0]   hit_vec;
    logic            valid;
    logic            sl_ack, sl_err, sl_rty;
    logic [DW-1:0]   sl_dat;
    logic            slave_term, unmapped, wd_hit;
    logic [NM-1:0]   req;
    logic [OW-1:0]   pick;
    logic            found;

    assign busy     = (state_q == BUSY);
    assign dbg_busy = busy;

    // Owner's slice of the flattened master buses
    always_comb begin
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_we  = 1'b0;
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        for (int k = 0; k < NM; k++) begin
            if (owner_q == OW'(k)) begin
                own_cyc = m_cyc_i[k];
                own_stb = m_stb_i[k];
                own_we  = m_we_i[k];
                own_adr = m_adr_i[k*AW +: AW];
                own_dat = m_dat_i[k*DW +: DW];
                own_sel = m_sel_i[k*SW +: SW];
            end
        end
    end

    assign own_req = busy && own_cyc && own_stb;
    assign dec     = own_adr[AW-1 -: SEL_BITS];

    always_comb begin
        hit_vec = '0;
        sl_ack  = 1'b0;
        sl_err  = 1'b0;
        sl_rty  = 1'b0;
        sl_dat  = '0;
        for (int i = 0; i < NS; i++) begin
            if (dec == SEL_BITS'(i)) begin
                hit_vec[i] = 1'b1;
                sl_ack     = s_ack_i[i];
                sl_err     = s_err_i[i];
                sl_rty     = s_rty_i[i];
                sl_dat     = s_dat_i[i*DW +: DW];
            end
        end
    end

    assign valid      = |hit_vec;
    assign slave_term = own_req && valid && (sl_ack || sl_err || sl_rty);
    assign unmapped   = own_req && !valid;
    // A genuine slave termination in the limit cycle wins over the timeout
    assign wd_hit     = own_req && valid && (wd_q == TO_LIMIT) && !slave_term;

    always_comb begin
        s_cyc_o = own_req ? hit_vec : '0;
        s_stb_o = (own_req && !wd_hit) ? hit_vec : '0;
        s_adr_o = busy ? own_adr : '0;
        s_dat_o = busy ? own_dat : '0;
        s_sel_o = busy ? own_sel : '0;
        s_we_o  = busy && own_we;
        m_dat_o = (busy && valid) ? sl_dat : '0;
        to_o    = wd_hit;
        m_ack_o = '0;
        m_err_o = '0;
        m_rty_o = '0;
        for (int k = 0; k < NM; k++) begin
            if (busy && owner_q == OW'(k)) begin
                m_ack_o[k] = valid && sl_ack;
                m_err_o[k] = (valid && sl_err) || unmapped || wd_hit;
                m_rty_o[k] = valid && sl_rty;
            end
        end
    end

    // Round-robin search starting just after the previous owner
    always_comb begin
        req   = m_cyc_i & m_stb_i;
        pick  = last_q;
        found = 1'b0;
        for (int j = 1; j <= NM; j++) begin
            if (!found && req[(int'(last_q) + j) % NM]) begin
                found = 1'b1;
                pick  = OW'((int'(last_q) + j) % NM);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = gnt_o;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                wd_d = '0;
                if (found) begin
                    state_d = BUSY;
                    owner_d = pick;
                    last_d  = pick;
                    gnt_d   = '0;
                    for (int k = 0; k < NM; k++) begin
                        if (pick == OW'(k)) gnt_d[k] = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (!own_cyc) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    wd_d    = '0;
                end else if (slave_term || unmapped || wd_hit) begin
                    wd_d = '0;
                end else if (own_req) begin
                    wd_d = wd_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                wd_d    = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= OW'(NM - 1);
            gnt_o   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_o   <= gnt_d;
            wd_q    <= wd_d;
        end
    end

endmodule

// File: tb/tb_wb_shared_bus.sv
// Bench for wb_shared_bus: table of single transfers with a scoreboard queue, plus hand-written
// sequences for round-robin handover and reset during a block cycle.
module tb_wb_shared_bus;

    localparam int NM = 2;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;
    localparam int W  = 84;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [NM-1:0]      m_cyc_i = '0, m_stb_i = '0, m_we_i = '0;
    logic [NM*AW-1:0]   m_adr_i = '0;
    logic [NM*DW-1:0]   m_dat_i = '0;
    logic [NM*DW/8-1:0] m_sel_i = '0;
    logic [DW-1:0]      m_dat_o;
    logic [NM-1:0]      m_ack_o, m_err_o, m_rty_o, gnt_o;
    logic [NS-1:0]      s_cyc_o, s_stb_o;
    logic [AW-1:0]      s_adr_o;
    logic [DW-1:0]      s_dat_o;
    logic [DW/8-1:0]    s_sel_o;
    logic               s_we_o, to_o, dbg_busy;
    logic [NS*DW-1:0]   s_dat_i;
    logic [NS-1:0]      s_ack_i, s_err_i, s_rty_i;

    wb_shared_bus #(.NM(NM), .NS(NS), .AW(AW), .DW(DW), .SEL_BITS(4), .TO_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_sel_o(s_sel_o), .s_we_o(s_we_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .gnt_o(gnt_o), .to_o(to_o), .dbg_busy(dbg_busy)
    );

    // Slave models: mode 0 ack, 1 err, 2 rty, 3 never; respond after lat strobed cycles
    int          slv_mode[NS];
    int          slv_lat[NS];
    logic [31:0] slv_dat[NS];
    logic [NS-1:0] resp_r;
    int          wcnt[NS];

    always @(posedge clk) begin
        for (int i = 0; i < NS; i++) begin
            if (!rst || resp_r[i]) begin
                resp_r[i] <= 1'b0;
                wcnt[i]   <= 0;
            end else if (s_cyc_o[i] && s_stb_o[i]) begin
                if (wcnt[i] + 1 >= slv_lat[i] && slv_mode[i] != 3) resp_r[i] <= 1'b1;
                else wcnt[i] <= wcnt[i] + 1;
            end else begin
                wcnt[i] <= 0;
            end
        end
    end

    always_comb begin
        s_ack_i = '0;
        s_err_i = '0;
        s_rty_i = '0;
        s_dat_i = '0;
        for (int i = 0; i < NS; i++) begin
            s_ack_i[i] = resp_r[i] && slv_mode[i] == 0;
            s_err_i[i] = resp_r[i] && slv_mode[i] == 1;
            s_rty_i[i] = resp_r[i] && slv_mode[i] == 2;
            s_dat_i[i*DW +: DW] = slv_dat[i];
        end
    end

    // Scoreboard
    logic [W-1:0] exp_q[$];
    logic [1:0]   gnt_q[$];
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] pack(input logic [2:0] resp, input logic to, input logic [31:0] rd,
                                          input logic [31:0] sd, input logic we, input logic [3:0] stb,
                                          input logic [1:0] gnt, input logic other, input int lat);
        return {resp, to, rd, sd, we, stb, gnt, other, 8'(lat)};
    endfunction

    task automatic run_xfer(input int m, input logic we, input logic [31:0] adr, input logic [31:0] wdat,
                            output logic [W-1:0] act, output bit done);
        int lat;
        @(negedge clk);
        m_cyc_i[m] = 1'b1;
        m_stb_i[m] = 1'b1;
        m_we_i[m]  = we;
        m_adr_i[m*AW +: AW] = adr;
        m_dat_i[m*DW +: DW] = wdat;
        m_sel_i[m*4 +: 4]   = 4'hF;
        done = 1'b0;
        act  = '0;
        lat  = 0;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (m_ack_o[m] || m_err_o[m] || m_rty_o[m]) begin
                act = pack({m_rty_o[m], m_err_o[m], m_ack_o[m]}, to_o, m_dat_o, s_dat_o, s_we_o,
                           s_stb_o, gnt_o, m_ack_o[1-m] | m_err_o[1-m] | m_rty_o[1-m], lat);
                done = 1'b1;
            end
        end
        m_cyc_i[m] = 1'b0;
        m_stb_i[m] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
    endtask

    typedef struct {
        int          m;
        logic        we;
        logic [31:0] adr;
        logic [31:0] wdat;
        int          mode;
        int          lat;
        logic [31:0] sdat;
        logic [2:0]  eresp;
        logic        eto;
        int          elat;
        logic [31:0] erd;
    } vec_t;

    vec_t vt[9];

    task automatic apply_vec(input string name, input vec_t v);
        int          slv;
        logic [3:0]  estb;
        logic [1:0]  egnt;
        logic [W-1:0] act, exp;
        bit          done;
        slv = int'(v.adr[31:28]);
        if (slv < NS) begin
            slv_mode[slv] = v.mode;
            slv_lat[slv]  = v.lat;
            slv_dat[slv]  = v.sdat;
        end
        estb = (v.eto || slv >= NS) ? 4'b0000 : 4'(1 << slv);
        egnt = 2'(1 << v.m);
        exp_q.push_back(pack(v.eresp, v.eto, v.erd, v.wdat, v.we, estb, egnt, 1'b0, v.elat));
        run_xfer(v.m, v.we, v.adr, v.wdat, act, done);
        exp = exp_q.pop_front();
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s no termination want %h", name, exp);
        end else begin
            chk(name, act, exp);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout");
        $fatal(1, "bench time limit");
    end

    initial begin
        vec_t rv;
        logic [1:0] gexp[12];
        bit   rearm[NM];

        for (int i = 0; i < NS; i++) begin
            slv_mode[i] = 0;
            slv_lat[i]  = 1;
            slv_dat[i]  = '0;
        end

        vt[0] = '{0, 1'b0, 32'h1000_0004, 32'h0000_0000, 0, 1, 32'hDEAD_BEEF, 3'b001, 1'b0, 2, 32'hDEAD_BEEF};
        vt[1] = '{1, 1'b1, 32'h5000_0000, 32'hA5A5_A5A5, 0, 1, 32'h0,         3'b010, 1'b0, 1, 32'h0};
        vt[2] = '{0, 1'b0, 32'h0000_0010, 32'h0000_1111, 0, 3, 32'h1234_5678, 3'b001, 1'b0, 4, 32'h1234_5678};
        vt[3] = '{1, 1'b1, 32'h3000_0020, 32'h55AA_55AA, 1, 1, 32'hCAFE_F00D, 3'b010, 1'b0, 2, 32'hCAFE_F00D};
        vt[4] = '{0, 1'b0, 32'h2000_0000, 32'h0000_2222, 2, 2, 32'h0F0F_0F0F, 3'b100, 1'b0, 3, 32'h0F0F_0F0F};
        vt[5] = '{1, 1'b0, 32'hF000_0000, 32'h0000_3333, 0, 1, 32'h0,         3'b010, 1'b0, 1, 32'h0};
        vt[6] = '{0, 1'b0, 32'h2000_0040, 32'h0000_4444, 3, 1, 32'h0BAD_F00D, 3'b010, 1'b1, TO + 1, 32'h0BAD_F00D};
        vt[7] = '{1, 1'b0, 32'h1000_0000, 32'h0000_5555, 0, TO, 32'h8765_4321, 3'b001, 1'b0, TO + 1, 32'h8765_4321};
        vt[8] = '{0, 1'b1, 32'h3000_0000, 32'h0102_0304, 0, 7, 32'h1357_9BDF, 3'b001, 1'b0, 8, 32'h1357_9BDF};

        // Reset state
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", W'({gnt_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o, to_o, dbg_busy}), '0);
        chk("reset_bus", W'({s_adr_o, s_dat_o, s_sel_o, s_we_o}), '0);
        chk("reset_mdat", W'(m_dat_o), '0);
        rst = 1'b1;

        for (int i = 0; i < 9; i++) apply_vec($sformatf("vec%0d", i), vt[i]);

        for (int i = 0; i < 8; i++) begin
            int slv;
            slv      = $urandom_range(0, 5);
            rv.m     = $urandom_range(0, 1);
            rv.we    = 1'($urandom_range(0, 1));
            rv.adr   = {4'(slv), 28'($urandom)};
            rv.wdat  = $urandom;
            rv.mode  = $urandom_range(0, 2);
            rv.lat   = $urandom_range(1, 6);
            rv.sdat  = $urandom;
            rv.eto   = 1'b0;
            if (slv >= NS) begin
                rv.eresp = 3'b010;
                rv.elat  = 1;
                rv.erd   = '0;
            end else begin
                rv.eresp = 3'(1 << rv.mode);
                rv.elat  = rv.lat + 1;
                rv.erd   = rv.sdat;
            end
            apply_vec($sformatf("rnd%0d", i), rv);
        end

        // Round-robin: both masters request together out of reset and keep re-requesting
        do_reset();
        slv_mode[1] = 0;
        slv_lat[1]  = 1;
        slv_dat[1]  = 32'h1111_1111;
        gexp = '{2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10, 2'b00};
        for (int c = 0; c < 12; c++) gnt_q.push_back(gexp[c]);
        @(negedge clk);
        for (int k = 0; k < NM; k++) begin
            m_adr_i[k*AW +: AW] = 32'h1000_0000;
            m_we_i[k]  = 1'b0;
            m_cyc_i[k] = 1'b1;
            m_stb_i[k] = 1'b1;
            rearm[k]   = 1'b0;
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            chk($sformatf("rr_gnt%0d", c), W'(gnt_o), W'(gnt_q.pop_front()));
            for (int k = 0; k < NM; k++) begin
                if (rearm[k]) begin
                    m_cyc_i[k] = 1'b1;
                    m_stb_i[k] = 1'b1;
                    rearm[k]   = 1'b0;
                end else if (m_ack_o[k]) begin
                    m_cyc_i[k] = 1'b0;
                    m_stb_i[k] = 1'b0;
                    rearm[k]   = 1'b1;
                end
            end
        end
        m_cyc_i = '0;
        m_stb_i = '0;
        repeat (2) @(negedge clk);

        // Reset during a block cycle owned by m1
        slv_mode[0] = 0;
        slv_lat[0]  = 1;
        m_adr_i[1*AW +: AW] = 32'h0000_0000;
        m_cyc_i[1] = 1'b1;
        m_stb_i[1] = 1'b1;
        repeat (3) @(negedge clk);
        chk("blk_gnt", W'(gnt_o), W'(2'b10));
        rst = 1'b0;
        m_adr_i[0*AW +: AW] = 32'h1000_0000;
        m_cyc_i[0] = 1'b1;
        m_stb_i[0] = 1'b1;
        @(negedge clk);
        chk("rst_mid", W'({gnt_o, s_cyc_o, s_stb_o, m_ack_o, m_err_o, m_rty_o, to_o, dbg_busy}), '0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_rr_m0", W'(gnt_o), W'(2'b01));
        m_cyc_i = '0;
        m_stb_i = '0;
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
